// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared constants for the multicycle MIPS control path:
//   - FSM state encoding (4 bits, also exported on state_o for debug)
//   - opcode and R-type funct field values
//   - ALU control codes and datapath mux select codes
//   - op_supported(): which opcodes the control FSM implements
// Optional feature macro used by the top level: MC_CTRL_PERF_EN.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // FSM state encoding
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand selects
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_A       = 1'b1;
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW)   || (op == OP_SW)  || (op == OP_RTYPE) ||
               (op == OP_BEQ)  || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// -----------------------------------------------------------------------------
// mc_alu_dec
// Combinational R-type funct decoder.
// Ports:
//   funct     in  6  IR[5:0]
//   alu_ctl   out 3  ALU operation; add for unsupported funct values
//   bad_funct out 1  funct is not one of add/sub/and/or/slt
// -----------------------------------------------------------------------------
module mc_alu_dec (
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       bad_funct
);
    import mc_ctrl_pkg::*;

    always_comb begin
        alu_ctl   = ALU_ADD;
        bad_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: bad_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Main control FSM of the multicycle MIPS datapath. Sequences register
// enables, mux selects, register-file writes and memory accesses over
// 3-5 cycles per instruction, stretching memory states until mem_ready.
//
// Parameter:
//   MEM_WAIT_MAX  consecutive wait cycles in a memory state before
//                 mem_timeout pulses (0 disables the watchdog)
// Ports:
//   CLK, RST                      clock (rising edge), async active-high reset
//   opcode, funct, zero           IR fields and ALU zero flag
//   mem_ready                     memory finishes the current access
//   mem_req, mem_write, iord      memory request / store / address select
//   ir_en, mdr_en, ab_en,
//   aluout_en, pc_en              datapath register enables
//   pc_src, alu_src_a, alu_src_b,
//   alu_ctl                       datapath selects and ALU operation
//   reg_write, reg_dst, mem_to_reg register file write controls
//   illegal_op, mem_timeout       one-cycle error pulses
//   state_o                       current state, for debug
// Optional feature (macro MC_CTRL_PERF_EN):
//   cycle_cnt, instr_cnt          free-running cycle and retired-instruction
//                                 counters, both wrapping modulo 2^32
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_en,
    output logic        mdr_en,
    output logic        ab_en,
    output logic        aluout_en,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctl,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [3:0]  state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);
    import mc_ctrl_pkg::*;

    // Watchdog counter wide enough to hold MEM_WAIT_MAX (saturation value).
    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_SAT  = CW'(MEM_WAIT_MAX);
    localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout_raw;
    logic [2:0]    rt_alu_ctl;
    logic          rt_bad_funct;

    mc_alu_dec u_alu_dec (
        .funct     (funct),
        .alu_ctl   (rt_alu_ctl),
        .bad_funct (rt_bad_funct)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTEX;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_RTEX:   state_nxt = S_RTWB;
            S_RTWB:   state_nxt = S_FETCH;
            S_BEQ:    state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;  // recover from unused encodings
        endcase
    end

    // A memory state never changes while mem_ready is low, so clearing the
    // counter whenever we are not waiting also covers every state change.
    assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                     && !mem_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                     wait_cnt <= '0;
        else if (!waiting)           wait_cnt <= '0;
        else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + CW'(1);
    end

    // Pulse on the MEM_WAIT_MAX-th consecutive wait cycle; the counter then
    // sits at saturation so the pulse cannot repeat within the same stall.
    assign timeout_raw = (MEM_WAIT_MAX != 0) && waiting && (wait_cnt == WAIT_LAST);

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_en       = 1'b0;
        mdr_en      = 1'b0;
        ab_en       = 1'b0;
        aluout_en   = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PCSRC_ALU;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_B;
        alu_ctl     = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = timeout_raw;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_4;
                ir_en     = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ab_en      = 1'b1;
                aluout_en  = 1'b1;
                alu_src_b  = SRCB_IMM_SL2;
                illegal_op = !op_supported(opcode);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                aluout_en = 1'b1;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mdr_en  = mem_ready;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTEX: begin
                alu_src_a  = SRCA_A;
                alu_src_b  = SRCB_B;
                alu_ctl    = rt_alu_ctl;
                aluout_en  = 1'b1;
                illegal_op = rt_bad_funct;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_B;
                alu_ctl   = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                aluout_en = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // The state already sits in FETCH during reset; mask the strobes so
        // nothing is written or requested until reset is released.
        if (RST) begin
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            ir_en       = 1'b0;
            mdr_en      = 1'b0;
            ab_en       = 1'b0;
            aluout_en   = 1'b0;
            pc_en       = 1'b0;
            reg_write   = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    assign state_o = state;

`ifdef MC_CTRL_PERF_EN
    // An instruction retires whenever the FSM re-enters FETCH from any
    // other state (only terminal states and illegal DECODE can do that).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if ((state != S_FETCH) && (state_nxt == S_FETCH))
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule
